// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I decode/execute boundary:
// opcodes, ALU operation codes, result-select encodings, immediate
// formats and the packed control bundle carried into Execute.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       alu_src_a;
    logic       jump_src;
    logic [1:0] result_src;
    alu_op_e    alu_ctrl;
    logic       illegal;
  } ctrl_t;

  // funct3 -> ALU op; bit30 picks SUB only for register-register ops,
  // and picks SRA for both register and immediate shifts.
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3,
                                                input logic       bit30,
                                                input logic       is_reg);
    case (funct3)
      3'b000:  return (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Two-read / one-write register file, x0 hardwired to zero, all entries
// cleared on reset. Build with WB_BYPASS_EN defined to forward the
// writeback data to a same-cycle read of the written address.
module reg_file #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_wa,
  input  logic [D_WIDTH-1:0] i_wd,
  input  logic [A_WIDTH-1:0] i_ra1,
  input  logic [A_WIDTH-1:0] i_ra2,
  output logic [D_WIDTH-1:0] o_rd1,
  output logic [D_WIDTH-1:0] o_rd2,
  output logic [D_WIDTH-1:0] o_x10
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic               w_hit1;
  logic               w_hit2;

  // Writeback port; writes aimed at x0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

`ifdef WB_BYPASS_EN
  assign w_hit1 = i_we && (i_wa != '0) && (i_wa == i_ra1);
  assign w_hit2 = i_we && (i_wa != '0) && (i_wa == i_ra2);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  assign o_rd1 = (i_ra1 == '0) ? '0 : (w_hit1 ? i_wd : r_mem[i_ra1]);
  assign o_rd2 = (i_ra2 == '0) ? '0 : (w_hit2 ? i_wd : r_mem[i_ra2]);
  assign o_x10 = r_mem[A_WIDTH'(10)];

endmodule

// File: rtl/decode_execute_stage.sv
// RV32I decode stage: combinational decoder and immediate generator feeding
// a registered D->E boundary with stall, flush and valid tracking.
// Optional macro: WB_BYPASS_EN (same-cycle writeback forwarding in reg_file).
module decode_execute_stage
  import decode_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int A_WIDTH    = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic [31:0]           InstrD,
  input  logic [D_WIDTH-1:0]    PCD,
  input  logic [D_WIDTH-1:0]    PCplus4D,
  input  logic                  WE3,
  input  logic [A_WIDTH-1:0]    A3,
  input  logic [D_WIDTH-1:0]    WD3,
  output logic [A_WIDTH-1:0]    Rs1D,
  output logic [A_WIDTH-1:0]    Rs2D,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic                  ALUSrcAE,
  output logic                  JumpSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUCtrlE,
  output logic [2:0]            Funct3E,
  output logic                  IllegalE,
  output logic [D_WIDTH-1:0]    RD1E,
  output logic [D_WIDTH-1:0]    RD2E,
  output logic [D_WIDTH-1:0]    ImmExtE,
  output logic [D_WIDTH-1:0]    PCE,
  output logic [D_WIDTH-1:0]    PCplus4E,
  output logic [A_WIDTH-1:0]    Rs1E,
  output logic [A_WIDTH-1:0]    Rs2E,
  output logic [A_WIDTH-1:0]    RdE,
  output logic [D_WIDTH-1:0]    A0
);

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic               w_bit30;
  logic [A_WIDTH-1:0] w_rd;
  ctrl_t              w_ctrl;
  imm_type_e          w_imm_type;
  logic [31:0]        w_imm32;
  logic [D_WIDTH-1:0] w_imm_ext;
  logic [D_WIDTH-1:0] w_rd1;
  logic [D_WIDTH-1:0] w_rd2;

  ctrl_t              r_ctrl;
  logic               r_valid;
  logic [2:0]         r_funct3;
  logic [D_WIDTH-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
  logic [A_WIDTH-1:0] r_rs1, r_rs2, r_rd;

  assign w_opcode = InstrD[6:0];
  assign w_funct3 = InstrD[14:12];
  assign w_bit30  = InstrD[30];
  assign w_rd     = A_WIDTH'(InstrD[11:7]);
  assign Rs1D     = A_WIDTH'(InstrD[19:15]);
  assign Rs2D     = A_WIDTH'(InstrD[24:20]);

  reg_file #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .i_we  (WE3),
    .i_wa  (A3),
    .i_wd  (WD3),
    .i_ra1 (Rs1D),
    .i_ra2 (Rs2D),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .o_x10 (A0)
  );

  // Opcode decode into the control bundle; anything illegal becomes an all-zero bundle with only the illegal flag set.
  always_comb begin
    w_ctrl     = '0;
    w_imm_type = IMM_NONE;
    case (w_opcode)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_ctrl  = alu_op_from_funct(w_funct3, w_bit30, 1'b1);
      end
      OP_I_ALU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = alu_op_from_funct(w_funct3, w_bit30, 1'b0);
        w_imm_type       = IMM_I;
        // bit30 is only meaningful on the right shift (SRAI); on SLLI it is reserved
        if (w_funct3 == 3'b001 && w_bit30) w_ctrl.illegal = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_imm_type        = IMM_I;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_type       = IMM_S;
      end
      OP_BRANCH: begin
        w_ctrl.branch   = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
        w_imm_type      = IMM_B;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm_type        = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.jump_src   = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm_type        = IMM_I;
      end
      OP_LUI: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_IMM;
        w_imm_type        = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_src_a = 1'b1;
        w_imm_type       = IMM_U;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
    if (w_ctrl.illegal) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
      w_imm_type     = IMM_NONE;
    end
  end

  // Immediate assembly per RV32I format, then sign extension from bit 31.
  always_comb begin
    w_imm32 = '0;
    case (w_imm_type)
      IMM_I:   w_imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   w_imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   w_imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_U:   w_imm32 = {InstrD[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm_ext = D_WIDTH'($signed(w_imm32));

  // D->E boundary: flush or an invalid slot loads a full bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushE || (!StallE && !ValidD)) begin
      if (!rst_n || FlushE || !StallE) begin
        r_ctrl   <= '0;
        r_valid  <= 1'b0;
        r_funct3 <= '0;
        r_rd1    <= '0;
        r_rd2    <= '0;
        r_imm    <= '0;
        r_pc     <= '0;
        r_pc4    <= '0;
        r_rs1    <= '0;
        r_rs2    <= '0;
        r_rd     <= '0;
      end
    end else if (!StallE) begin
      r_ctrl   <= w_ctrl;
      r_valid  <= 1'b1;
      r_funct3 <= w_funct3;
      r_rd1    <= w_rd1;
      r_rd2    <= w_rd2;
      r_imm    <= w_imm_ext;
      r_pc     <= PCD;
      r_pc4    <= PCplus4D;
      r_rs1    <= Rs1D;
      r_rs2    <= Rs2D;
      r_rd     <= w_rd;
    end
  end

  assign ValidE     = r_valid;
  assign RegWriteE  = r_ctrl.reg_write;
  assign MemWriteE  = r_ctrl.mem_write;
  assign JumpE      = r_ctrl.jump;
  assign BranchE    = r_ctrl.branch;
  assign ALUSrcE    = r_ctrl.alu_src;
  assign ALUSrcAE   = r_ctrl.alu_src_a;
  assign JumpSrcE   = r_ctrl.jump_src;
  assign ResultSrcE = r_ctrl.result_src;
  assign ALUCtrlE   = ALU_CTRL_W'(r_ctrl.alu_ctrl);
  assign IllegalE   = r_ctrl.illegal;
  assign Funct3E    = r_funct3;
  assign RD1E       = r_rd1;
  assign RD2E       = r_rd2;
  assign ImmExtE    = r_imm;
  assign PCE        = r_pc;
  assign PCplus4E   = r_pc4;
  assign Rs1E       = r_rs1;
  assign Rs2E       = r_rs2;
  assign RdE        = r_rd;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Randomized bench for decode_execute_stage against a field-level RV32I
// decode model and a plain array register-file model.
module tb_decode_execute_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE, ValidD, WE3;
  logic [31:0] InstrD, PCD, PCplus4D, WD3;
  logic [4:0]  A3;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, JumpSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUCtrlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCplus4E, A0;

  always #5 clk = ~clk;

  decode_execute_stage dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .InstrD(InstrD), .PCD(PCD), .PCplus4D(PCplus4D), .WE3(WE3), .A3(A3), .WD3(WD3),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .JumpSrcE(JumpSrcE),
    .ResultSrcE(ResultSrcE), .ALUCtrlE(ALUCtrlE), .Funct3E(Funct3E), .IllegalE(IllegalE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCplus4E(PCplus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .A0(A0)
  );

  typedef struct packed {
    logic        valid, rw, mw, jmp, br, as, asa, js;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        ill;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } e_t;

  e_t          exp_e;
  logic [31:0] mreg [32];
  int          total = 0;
  int          bad   = 0;
  int          txn   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s txn=%0d got=%h want=%h", tag, txn, obs, expv);
    end
  endtask

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic b30, input logic is_r);
    alu_op_e op;
    case (f3)
      3'd0: op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = b30 ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return 4'(op);
  endfunction

  // Immediates built arithmetically from field weights, sign handled by subtracting the MSB weight.
  function automatic logic [31:0] imm_i(input logic [31:0] x);
    int v;
    v = int'(x[31:20]);
    if (x[31]) v -= 4096;
    return 32'(v);
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] x);
    int v;
    v = int'(x[31:25]) * 32 + int'(x[11:7]);
    if (x[31]) v -= 4096;
    return 32'(v);
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] x);
    int v;
    v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
    if (x[31]) v -= 4096;
    return 32'(v);
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] x);
    int v;
    v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
    if (x[31]) v -= 1048576;
    return 32'(v);
  endfunction

  function automatic e_t model_decode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] pc, input logic [31:0] pc4);
    e_t   e;
    logic ill;
    logic [2:0] f3;
    e   = '0;
    ill = 1'b0;
    f3  = ins[14:12];
    e.valid = 1'b1; e.f3 = f3;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.rd1 = r1; e.rd2 = r2; e.pc = pc; e.pc4 = pc4;
    case (ins[6:0])
      7'h33: begin e.rw = 1; e.alu = alu_code(f3, ins[30], 1'b1); end
      7'h13: begin
        e.rw = 1; e.as = 1; e.imm = imm_i(ins);
        if (f3 == 3'd1 && ins[30]) ill = 1'b1;
        else e.alu = alu_code(f3, ins[30], 1'b0);
      end
      7'h03: begin e.rw = 1; e.as = 1; e.res = 2'b01; e.imm = imm_i(ins); end
      7'h23: begin e.mw = 1; e.as = 1; e.imm = imm_s(ins); end
      7'h63: begin e.br = 1; e.alu = 4'(ALU_SUB); e.imm = imm_b(ins); end
      7'h6F: begin e.rw = 1; e.jmp = 1; e.res = 2'b10; e.imm = imm_j(ins); end
      7'h67: begin e.rw = 1; e.jmp = 1; e.js = 1; e.as = 1; e.res = 2'b10; e.imm = imm_i(ins); end
      7'h37: begin e.rw = 1; e.as = 1; e.res = 2'b11; e.imm = ins & 32'hFFFF_F000; end
      7'h17: begin e.rw = 1; e.as = 1; e.asa = 1; e.imm = ins & 32'hFFFF_F000; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.rw = 0; e.mw = 0; e.jmp = 0; e.br = 0; e.as = 0; e.asa = 0; e.js = 0;
      e.res = 2'b00; e.alu = 4'd0; e.imm = '0; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (WE3 && A3 == a) return WD3;
`endif
    return mreg[a];
  endfunction

  task automatic compare_all();
    chk("ValidE", ValidE, exp_e.valid);       chk("RegWriteE", RegWriteE, exp_e.rw);
    chk("MemWriteE", MemWriteE, exp_e.mw);    chk("JumpE", JumpE, exp_e.jmp);
    chk("BranchE", BranchE, exp_e.br);        chk("ALUSrcE", ALUSrcE, exp_e.as);
    chk("ALUSrcAE", ALUSrcAE, exp_e.asa);     chk("JumpSrcE", JumpSrcE, exp_e.js);
    chk("ResultSrcE", ResultSrcE, exp_e.res); chk("ALUCtrlE", ALUCtrlE, exp_e.alu);
    chk("Funct3E", Funct3E, exp_e.f3);        chk("IllegalE", IllegalE, exp_e.ill);
    chk("RD1E", RD1E, exp_e.rd1);             chk("RD2E", RD2E, exp_e.rd2);
    chk("ImmExtE", ImmExtE, exp_e.imm);       chk("PCE", PCE, exp_e.pc);
    chk("PCplus4E", PCplus4E, exp_e.pc4);     chk("Rs1E", Rs1E, exp_e.rs1);
    chk("Rs2E", Rs2E, exp_e.rs2);             chk("RdE", RdE, exp_e.rd);
    chk("A0", A0, mreg[10]);
  endtask

  task automatic clear_model();
    exp_e = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
  endtask

  // One clock of stimulus: drive at negedge, predict, check #1 after the posedge.
  task automatic step(input logic [31:0] ins, input logic vd, input logic st, input logic fl,
                      input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    e_t nxt;
    @(negedge clk);
    InstrD = ins; ValidD = vd; StallE = st; FlushE = fl;
    WE3 = we; A3 = a3; WD3 = wd; PCD = pc; PCplus4D = pc + 32'd4;
    #1;
    chk("Rs1D", Rs1D, ins[19:15]);
    chk("Rs2D", Rs2D, ins[24:20]);
    if (fl)       nxt = '0;
    else if (st)  nxt = exp_e;
    else if (!vd) nxt = '0;
    else          nxt = model_decode(ins, model_read(ins[19:15]), model_read(ins[24:20]), pc, pc + 32'd4);
    if (we && a3 != 5'd0) mreg[a3] = wd;
    @(posedge clk);
    #1;
    exp_e = nxt;
    txn++;
    $display("txn %0d instr=%h vd=%b st=%b fl=%b we=%b a3=%0d -> ValidE=%b RdE=%0d Imm=%h RD1E=%h",
             txn, ins, vd, st, fl, we, a3, ValidE, RdE, ImmExtE, RD1E);
    compare_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 9)];
    if (ins[6:0] == 7'h7F && $urandom_range(0, 1) == 1) ins[6:0] = 7'(7'h0B);
    return ins;
  endfunction

  task automatic random_steps(input int n);
    logic [31:0] ins;
    logic [4:0]  a3;
    for (int k = 0; k < n; k++) begin
      ins = rand_instr();
      a3  = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
      step(ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
           $urandom_range(0, 1) == 1, a3, $urandom, $urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; StallE = 0; FlushE = 0; ValidD = 0; InstrD = '0;
    PCD = '0; PCplus4D = '0; WE3 = 0; A3 = '0; WD3 = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // addi x5,x0,-3
    step(32'hFFD00293, 1, 0, 0, 0, 5'd0, 32'd0, 32'h100);
    chk("addi_imm", ImmExtE, 32'hFFFF_FFFD);
    chk("addi_rd", RdE, 5'd5);
    chk("addi_alu", ALUCtrlE, 4'(ALU_ADD));
    chk("addi_rw_src", {RegWriteE, ALUSrcE}, 2'b11);

    // write x10, then read it back through addi x1,x10,0
    step(32'h00000013, 1, 0, 0, 1, 5'd10, 32'h1234, 32'h104);
    step(32'h00050093, 1, 0, 0, 0, 5'd0, 32'd0, 32'h108);
    chk("x10_rd1", RD1E, 32'h1234);
    chk("x10_a0", A0, 32'h1234);

    // attempted write to x0 is ignored
    step(32'h00000013, 1, 0, 0, 1, 5'd0, 32'hFFFF, 32'h10C);
    step(32'h00000093, 1, 0, 0, 0, 5'd0, 32'd0, 32'h110);
    chk("x0_rd1", RD1E, 32'd0);

    // same-cycle write of x7 and read of x7
    step(32'h00038093, 1, 0, 0, 1, 5'd7, 32'hAA, 32'h114);
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", RD1E, 32'hAA);
`else
    chk("bypass_rd1", RD1E, 32'h0);
`endif

    // capture, then three stalled cycles with changing inputs
    step(32'h00A38293, 1, 0, 0, 0, 5'd0, 32'd0, 32'h200);
    for (int k = 0; k < 3; k++) step(rand_instr(), 1, 1, 0, 0, 5'd0, 32'd0, $urandom);
    chk("stall_pc", PCE, 32'h200);

    // stall and flush together: flush wins
    step(32'h00A38293, 1, 1, 1, 0, 5'd0, 32'd0, 32'h204);
    chk("stflush_valid", ValidE, 1'b0);
    chk("stflush_rw", RegWriteE, 1'b0);

    // beq x0,x0,-4
    step(32'hFE000EE3, 1, 0, 0, 0, 5'd0, 32'd0, 32'h208);
    chk("beq_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("beq_br", BranchE, 1'b1);

    // unknown opcode 0x7F
    step(32'h0000007F, 1, 0, 0, 0, 5'd0, 32'd0, 32'h20C);
    chk("ill_flag", IllegalE, 1'b1);
    chk("ill_ctrl", {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE}, 5'b0);

    random_steps(400);

    // asynchronous reset between edges while a stall is requested
    @(negedge clk);
    StallE = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    StallE = 1'b0;

    random_steps(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
